// File: rtl/mux_pipe_n.sv
// mux_pipe_n: N-input select mux feeding a registered output stage with a
// one-entry skid buffer. in_ready is a flop (inverse of skid occupancy), so
// upstream never sees a combinational path from out_ready.

// Per-input lane: passes its data slice only when the select hits its index.
module mux_pipe_n_lane #(
  parameter int WIDTH = 5,
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  assign dout = (sel == SEL_W'(IDX)) ? din : '0;
endmodule

module mux_pipe_n #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic                    sel_err,
  output logic [15:0]             beat_cnt
);
  // NUM_IN widened by one bit so 16 inputs with a 4-bit select still compare.
  localparam logic [SEL_W:0] NUM_IN_C = (SEL_W+1)'(NUM_IN);

  logic [NUM_IN-1:0][WIDTH-1:0] lane_out;
  logic [WIDTH-1:0]             sel_val;
  logic                         sel_oor;
  logic                         accept;
  logic                         emit;

  logic [WIDTH-1:0] skid_data, skid_data_n, out_data_n;
  logic             skid_valid, skid_valid_n, out_valid_n;

  assign accept  = in_valid && in_ready && !flush;
  assign emit    = out_valid && out_ready;
  assign sel_oor = {1'b0, in_sel} >= NUM_IN_C;

  // One lane per input; an out-of-range select hits no lane and yields zero.
  for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
    mux_pipe_n_lane #(.WIDTH(WIDTH), .SEL_W(SEL_W), .IDX(g)) u_lane (
      .sel  (in_sel),
      .din  (in_data[g*WIDTH +: WIDTH]),
      .dout (lane_out[g])
    );
  end

  // OR-combine the one-hot lane outputs.
  always_comb begin
    sel_val = '0;
    for (int k = 0; k < NUM_IN; k++) sel_val |= lane_out[k];
  end

  // Next-state for output and skid registers; flush wins over everything.
  always_comb begin
    out_data_n   = out_data;
    out_valid_n  = out_valid;
    skid_data_n  = skid_data;
    skid_valid_n = skid_valid;
    if (flush) begin
      out_valid_n  = 1'b0;
      skid_valid_n = 1'b0;
    end else if (emit && skid_valid) begin
      // Skid drains into the output; a same-cycle beat refills the skid.
      out_data_n   = skid_data;
      out_valid_n  = 1'b1;
      skid_valid_n = accept;
      if (accept) skid_data_n = sel_val;
    end else if (accept) begin
      if (!out_valid || emit) begin
        out_data_n  = sel_val;
        out_valid_n = 1'b1;
      end else begin
        skid_data_n  = sel_val;
        skid_valid_n = 1'b1;
      end
    end else if (emit) begin
      out_valid_n = 1'b0;
    end
  end

  // Data/valid storage; data words hold their value when valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else begin
      out_data   <= out_data_n;
      out_valid  <= out_valid_n;
      skid_data  <= skid_data_n;
      skid_valid <= skid_valid_n;
    end
  end

  // Registered ready: open whenever the skid will be empty next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_ready <= 1'b0;
    else        in_ready <= !skid_valid_n;
  end

  // Sticky out-of-range select flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 sel_err <= 1'b0;
    else if (accept && sel_oor) sel_err <= 1'b1;
  end

  // Accepted-beat counter, free-running wrap, unaffected by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      beat_cnt <= '0;
    else if (accept) beat_cnt <= beat_cnt + 16'd1;
  end
endmodule

// File: tb/tb_mux_pipe_n.sv
// Scoreboard bench for mux_pipe_n: the driver pushes expected beats when the
// reference stage would accept; a monitor pops on every observed handshake.
module tb_mux_pipe_n;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic        in_ready, out_valid, sel_err;
  logic [4:0]  out_data;
  logic [15:0] beat_cnt;

  // Second, 3-input instance for out-of-range select behaviour.
  logic [14:0] b_in_data = '0;
  logic [1:0]  b_in_sel = '0;
  logic        b_in_valid = 1'b0, b_out_ready = 1'b1, b_flush = 1'b0;
  logic        b_in_ready, b_out_valid, b_sel_err;
  logic [4:0]  b_out_data;
  logic [15:0] b_beat_cnt;

  int          n_vec = 0, n_err = 0;
  logic [4:0]  q[$];
  logic [15:0] mdl_cnt = '0;
  logic        live = 1'b0;
  logic        exp_rdy = 1'b0;

  mux_pipe_n #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .sel_err(sel_err), .beat_cnt(beat_cnt));

  mux_pipe_n #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_in_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .flush(b_flush),
    .sel_err(b_sel_err), .beat_cnt(b_beat_cnt));

  initial forever #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_mux(input logic [19:0] d, input logic [1:0] s);
    logic [19:0] t;
    t = d >> (5 * s);
    return t[4:0];
  endfunction

  // Reference: the stage opens one edge after reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;

  // Monitor: compare visible state to the model, pop on handshake, clear on flush.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_rdy = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_beat_cnt", beat_cnt, 0);
      chk("rst_sel_err", sel_err, 0);
    end else begin
      exp_rdy = live && (q.size() < 2);
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, q.size() != 0);
      chk("beat_cnt", beat_cnt, mdl_cnt);
      chk("sel_err", sel_err, 0);
      if (q.size() != 0) chk("out_data", out_data, q[0]);
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (flush) q.delete();
    end
  end

  // One cycle of stimulus; starts and ends 1 time unit after a rising edge.
  task automatic cycle(input logic v, input logic [1:0] s, input logic [19:0] d,
                       input logic ordy, input logic fl, output logic acc);
    in_valid = v; in_sel = s; in_data = d; out_ready = ordy; flush = fl;
    @(negedge clk); #1;
    acc = v && exp_rdy && !fl;
    if (acc) begin
      q.push_back(ref_mux(d, s));
      mdl_cnt++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic        a, ok;
    logic [15:0] cnt_before;
    logic [19:0] bus;
    int          g;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // First edge after release must not accept.
    cycle(1, 2'd1, 20'h12345, 1, 0, a);
    chk("no_accept_first_edge", a, 0);

    // Four consecutive selects, out_ready high.
    bus = {5'h1F, 5'h15, 5'h0A, 5'h03};
    for (int i = 0; i < 4; i++) cycle(1, 2'(i), bus, 1, 0, a);
    cycle(0, 0, 0, 1, 0, a);

    // Stall: A in output, B in skid, C held off until drain.
    cycle(0, 0, 0, 1, 0, a);
    cycle(1, 0, 20'h00011, 0, 0, a);
    chk("A_accept", a, 1);
    cycle(1, 0, 20'h00012, 0, 0, a);
    chk("B_accept", a, 1);
    chk("skid_full_rdy", in_ready, 0);
    chk("hold_A", out_data, 5'h11);
    cycle(1, 0, 20'h00013, 0, 0, a);
    chk("C_held", a, 0);
    chk("hold_A2", out_data, 5'h11);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      cycle(1, 0, 20'h00013, 1, 0, a);
      ok = a;
    end
    chk("C_accept", ok, 1);
    repeat (3) cycle(0, 0, 0, 1, 0, a);

    // Random traffic.
    repeat (1500)
      cycle($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), 20'($urandom),
            $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0, a);
    repeat (3) cycle(0, 0, 0, 1, 0, a);

    // Flush with both registers full and a beat offered.
    cycle(1, 2'd1, 20'($urandom), 0, 0, a);
    cycle(1, 2'd3, 20'($urandom), 0, 0, a);
    chk("full_rdy", in_ready, 0);
    cnt_before = mdl_cnt;
    cycle(1, 2'd2, 20'($urandom), 0, 1, a);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_beat_cnt", beat_cnt, cnt_before);

    // 3-input instance: valid select, then out-of-range select, then flush.
    in_valid = 1'b0; flush = 1'b0;
    b_in_data = 15'($urandom); b_in_sel = 2'd2; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    chk("b_out_valid", b_out_valid, 1);
    chk("b_sel2_data", b_out_data, b_in_data[14:10]);
    chk("b_sel_err_clean", b_sel_err, 0);
    b_in_data = 15'($urandom) | 15'h0001; b_in_sel = 2'd3; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    chk("b_oor_data", b_out_data, 0);
    chk("b_sel_err_set", b_sel_err, 1);
    chk("b_beat_cnt", b_beat_cnt, 2);
    b_flush = 1'b1;
    @(posedge clk); #1;
    b_flush = 1'b0;
    chk("b_flush_valid", b_out_valid, 0);
    chk("b_sel_err_sticky", b_sel_err, 1);
    chk("b_flush_rdy", b_in_ready, 1);

    // Counter wrap.
    g = 0;
    while (mdl_cnt != 16'hFFFF && g < 70000) begin
      cycle(1, 2'($urandom_range(0, 3)), 20'($urandom), 1, 0, a);
      g++;
    end
    chk("cnt_ffff", beat_cnt, 16'hFFFF);
    cycle(1, 2'd0, 20'($urandom), 1, 0, a);
    chk("cnt_wrap", beat_cnt, 16'h0000);

    // Reset mid-stream with output and skid occupied.
    cycle(1, 2'd1, 20'($urandom), 0, 0, a);
    cycle(1, 2'd2, 20'($urandom), 0, 0, a);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 0);
    chk("async_out_data", out_data, 0);
    chk("async_beat_cnt", beat_cnt, 0);
    chk("async_b_sel_err", b_sel_err, 0);
    q.delete();
    mdl_cnt = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_rdy_low", in_ready, 0);
    repeat (3) cycle(0, 0, 0, 1, 0, a);
    cycle(1, 2'd3, 20'($urandom), 1, 0, a);
    chk("post_rst_accept", a, 1);
    repeat (2) cycle(0, 0, 0, 1, 0, a);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mux_pipe_n.md
MUX_PIPE_N -- requirements
Module: mux_pipe_n

Interface
REQ-001 Parameter WIDTH, default 5: data width of each input and of the output, in bits.
REQ-002 Parameter NUM_IN, default 4: number of data inputs, range 2..16 (power of 2 not required).
REQ-003 Parameter SEL_W, default 2: select width; SHALL equal ceil(log2(NUM_IN)).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  NUM_IN*WIDTH  flat input bus; input k occupies bits [k*WIDTH +: WIDTH].
REQ-007 in_sel  input  SEL_W  index of the input to capture.
REQ-008 in_valid  input  1  upstream offers a beat.
REQ-009 in_ready  output  1  stage can accept a beat; driven directly from a register.
REQ-010 out_data  output  WIDTH  registered selected data.
REQ-011 out_valid  output  1  out_data holds a beat.
REQ-012 out_ready  input  1  downstream accepts the beat (0 = stall).
REQ-013 flush  input  1  synchronous pipeline flush.
REQ-014 sel_err  output  1  sticky flag: an out-of-range select was accepted.
REQ-015 beat_cnt  output  16  count of accepted input beats.

Function
REQ-016 The selected value SHALL be in_data[in_sel*WIDTH +: WIDTH] when in_sel < NUM_IN, and all-zero otherwise.
REQ-017 Accept condition: in_valid && in_ready && !flush. Emit condition: out_valid && out_ready.
REQ-018 Storage: one output register (out_data/out_valid) and one skid register (skid_data/skid_valid); no other data storage.
REQ-019 in_ready SHALL equal !skid_valid as registered state; it SHALL NOT depend combinationally on out_ready.
REQ-020 On accept, the beat SHALL go to the output register if !out_valid or the emit condition holds; otherwise it SHALL go to the skid register.
REQ-021 On emit with skid_valid=1, skid content SHALL move to the output register and skid_valid SHALL clear in the same cycle.
REQ-022 If emit, skid_valid=1 and accept all occur in the same cycle, the skid moves to the output and the new beat goes to the skid.
REQ-023 Latency: an accepted beat into an empty stage SHALL be on out_data/out_valid the next cycle.
REQ-024 Throughput: with out_ready held at 1, the stage SHALL accept one beat per cycle with no bubbles.
REQ-025 While out_valid=1 and out_ready=0, out_data SHALL be held stable.
REQ-026 Beats SHALL emit in acceptance order; none dropped or duplicated except by flush.
REQ-027 flush=1 SHALL clear out_valid and skid_valid on the next edge and SHALL discard any same-cycle input beat; flush has priority over all other events.
REQ-028 out_data and skid_data SHALL keep their values when their valid bit clears.
REQ-029 sel_err SHALL set on the edge after an accept with in_sel >= NUM_IN, and clear only on reset (flush does not clear it).
REQ-030 beat_cnt SHALL increment by 1 per accept, wrap 0xFFFF -> 0x0000, and ignore flush.

Reset
REQ-031 While rst_n=0: out_valid=0, skid_valid=0, in_ready=0, out_data=0, skid_data=0, sel_err=0, beat_cnt=0, regardless of clk.
REQ-032 On the first rising clk edge after rst_n deasserts, in_ready SHALL become 1; no beat is accepted on that edge.
REQ-033 Reset asserted mid-transfer SHALL discard all held beats immediately; no partial beat may emit afterward.

Verification
REQ-034 WIDTH=5, NUM_IN=4, out_ready=1; inputs {0x03,0x0A,0x15,0x1F}; sel 0,1,2,3 on consecutive cycles -> out_data 0x03,0x0A,0x15,0x1F on cycles 1..4, out_valid continuous.
REQ-035 out_ready=0; offer beats A=0x11, B=0x12 -> A on out held, B in skid, in_ready=0; C held off; raise out_ready -> A, B, C emit in order, no loss.
REQ-036 NUM_IN=3, sel=3 accepted -> out_data=0, sel_err=1 next cycle; sel_err stays 1 after flush, clears only on rst_n=0.
REQ-037 Output and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, skid_valid=0, in_ready=1, beat_cnt unchanged by the flushed beat.
REQ-038 Preload beat_cnt to 0xFFFF via 65535 accepts; one more accept -> beat_cnt=0x0000; rst_n pulsed low mid-stream -> all outputs reset immediately.
